hardmatchblock_param: RTL and testbench
=======================================

Name: hardmatchblock_param

Overview:
Parametrised successor to the fixed 128-bit hard match block. Accepts a beat stream of tagged packets and extracts a key from the SOP beat. It matches the key against a runtime-programmable table of masked rules, and returns one result word per packet, {hit, rule index, tag}, through a buffered valid/ack output. It sits between the packet-node parser and the downstream action stage.

Parameters:
DATA_W, 128, payload bits per beat
TAG_W, 8, packet tag width; the tag is carried in the top bits of the beat
KEY_W, 32, match key width
KEY_LSB, 96, bit offset of the key within the SOP beat payload; KEY_LSB+KEY_W <= DATA_W
NUM_RULES, 16, number of rule entries (power of 2, >=2)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clock  in  1  single clock
resetn  in  1  asynchronous active-low reset
pnode_data  in  DATA_W+2+TAG_W  beat: [DATA_W+1+TAG_W:DATA_W+2]=tag, [DATA_W+1]=sop, [DATA_W]=eop, [DATA_W-1:0]=payload
pnode_valid  in  1  beat valid
pnode_ready  out  1  beat accepted when valid&ready
cfg_we  in  1  rule write strobe
cfg_addr  in  $clog2(NUM_RULES)  rule index
cfg_en  in  1  rule enable
cfg_key  in  KEY_W  rule key
cfg_mask  in  KEY_W  1 = bit compared
data_valid  out  1  result available
data_ack  in  1  result consumed when valid&ack
data_out  out  1+$clog2(NUM_RULES)+TAG_W  {hit, idx, tag}
err_count  out  16  protocol-error count, saturating

Behaviour:
- Reset (resetn low, async): pnode_ready=0, data_valid=0, data_out=0, err_count=0, FIFO empty, pipe empty, parser IDLE, all rule enables=0. Rule keys and masks are not reset. pnode_ready rises on the first clock after release.
- pnode_ready = (fifo_count + inflight) < FIFO_DEPTH. It is registered, and it counts space reserved by packets in the parser and in the match pipe.
- Parser FSM:
  - IDLE: an accepted beat with sop=1 latches key=payload[KEY_LSB+:KEY_W] and the tag. If eop is also 1 on that beat, it launches to the pipe and stays in IDLE; otherwise it goes to BODY. An accepted beat with sop=0 is dropped and increments err_count.
  - BODY: an accepted beat with eop=1 launches {key, tag} into the pipe and returns to IDLE. An accepted beat with sop=1 aborts the current packet (no result, err_count+1) and restarts as a new SOP, following the same rules as IDLE.
  - Beats with valid=0 or ready=0 have no effect.
- Match pipe, 2 stages:
  - S1 registers {key, tag}, evaluates hit_i = en_i & ((key ^ rule_key_i) & rule_mask_i)==0 for all i, and registers the hit vector.
  - S2 priority-encodes the lowest index with hit_i=1. A miss gives hit=0, idx=0.
  - S2 pushes into the FIFO. Latency from the accepted eop beat to data_valid on an empty FIFO is 3 clocks.
- Rule table: a cfg_we write takes effect on the next clock. The S1 compare uses the table contents in its own cycle. A write in the same cycle as S1 uses the old value.
- Output: data_out and data_valid come from the FIFO head. data_out must stay stable while data_valid & !data_ack. A pop and a push in the same cycle are both allowed and leave the count unchanged. FIFO overflow cannot happen because of the reservation; a push on a full FIFO is an assertion error.
- err_count saturates at 16'hFFFF.
- Back-to-back single-beat packets are sustained at 1 per clock while data_ack is held high.

Decomposition:
- Package hardmatch_pkg:
  - beat-field offset functions (tag/sop/eop positions from DATA_W, TAG_W)
  - result struct {hit, idx, tag}
  - FSM enum {IDLE, BODY}
- One sub-module, hardmatch_result_fifo: parametrised sync FIFO with count output and first-word-fall-through head.
- Rule compare and priority encoder stay inline.

Test Plan:
- Reset, all rules disabled; send 6-beat packets with tags 0..255 and random data_ack (25% duty) -> data_out = {0, 0, tag} in tag order, no losses, no duplicates, err_count=0.
- Rule 3 = key 32'hDEAD_BEEF, mask all-ones, en=1; rule 1 = key 32'hDEAD_0000, mask 32'hFFFF_0000, en=1; send key 32'hDEAD_BEEF, tag 8'h5A -> data_out = {1, 4'd1, 8'h5A} 3 clocks after eop.
- data_ack held 0; stream single-beat packets -> exactly 4 results buffered, pnode_ready falls after the 4th accepted packet. Assert data_ack for 1 clock -> ready returns, next result is in order.
- Beat with sop=0 in IDLE, then sop in BODY mid-packet -> err_count=2; only packets with a matching sop..eop produce results.
- Rewrite rule 1 to en=0 on the same cycle a matching key sits in S1 -> that packet hits idx 1; the next identical packet hits idx 3.
- Drop resetn mid-packet with 2 results queued -> data_valid=0 and err_count=0 immediately. After release, a new packet produces a miss result with its own tag.

Source files
------------

// File: rtl/hardmatch_pkg.sv
// Shared types and beat-layout helpers for the parametrised hard match block.
// A beat is {tag, sop, eop, payload}, with the payload in the low DATA_W bits.
package hardmatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } parse_state_t;

  function automatic int beat_width(input int data_w, input int tag_w);
    return data_w + 2 + tag_w;
  endfunction

  function automatic int beat_eop_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int beat_sop_pos(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int beat_tag_lsb(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/hardmatch_result_fifo.sv
// Synchronous result FIFO with a first-word-fall-through head and occupancy count.
// The head word is read straight from storage, so it holds steady until popped.
module hardmatch_result_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_fire;

  assign pop_fire = pop & (count_reg != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop_fire);
    end
  end

  // Storage is not reset; the head is qualified by head_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  assign head_data  = mem_reg[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    !(push && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/hardmatchblock_param.sv
// Masked-rule key matcher: parses tagged packets, compares the SOP key against a
// programmable rule table and queues one {hit, idx, tag} result per packet.
module hardmatchblock_param
  import hardmatch_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int TAG_W      = 8,
  parameter int KEY_W      = 32,
  parameter int KEY_LSB    = 96,
  parameter int NUM_RULES  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [beat_width(DATA_W, TAG_W)-1:0] pnode_data,
  input  logic                                pnode_valid,
  output logic                                pnode_ready,
  input  logic                                cfg_we,
  input  logic [$clog2(NUM_RULES)-1:0]        cfg_addr,
  input  logic                                cfg_en,
  input  logic [KEY_W-1:0]                    cfg_key,
  input  logic [KEY_W-1:0]                    cfg_mask,
  output logic                                data_valid,
  input  logic                                data_ack,
  output logic [$clog2(NUM_RULES)+TAG_W:0]    data_out,
  output logic [15:0]                         err_count
);

  localparam int IDX_W   = $clog2(NUM_RULES);
  localparam int RES_W   = 1 + IDX_W + TAG_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TOT_W   = CNT_W + 2;
  localparam int TAG_LSB = beat_tag_lsb(DATA_W);
  localparam int SOP_POS = beat_sop_pos(DATA_W);
  localparam int EOP_POS = beat_eop_pos(DATA_W);

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } result_t;

  logic [TAG_W-1:0] beat_tag;
  logic             beat_sop;
  logic             beat_eop;
  logic [KEY_W-1:0] beat_key;
  logic             unused_beat;

  assign beat_tag    = pnode_data[TAG_LSB +: TAG_W];
  assign beat_sop    = pnode_data[SOP_POS];
  assign beat_eop    = pnode_data[EOP_POS];
  assign beat_key    = pnode_data[KEY_LSB +: KEY_W];
  assign unused_beat = ^pnode_data;

  parse_state_t     state_reg;
  logic [KEY_W-1:0] key_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             ready_reg;
  logic [15:0]      err_count_reg;

  logic             s1_valid_reg;
  logic [KEY_W-1:0] s1_key_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s2_valid_reg;
  logic [NUM_RULES-1:0] s2_hit_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  logic accept;
  logic open_pkt;
  logic err_event;

  assign accept    = pnode_valid & ready_reg;
  assign open_pkt  = accept & beat_sop & (state_reg == IDLE);
  assign err_event = accept & (beat_sop ? (state_reg == BODY) : (state_reg == IDLE));

  // Parser: an SOP always restarts a packet; a single-beat packet launches directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      tag_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_key_reg   <= '0;
      s1_tag_reg   <= '0;
    end else begin
      s1_valid_reg <= 1'b0;
      if (accept) begin
        if (beat_sop) begin
          key_reg <= beat_key;
          tag_reg <= beat_tag;
          if (beat_eop) begin
            s1_valid_reg <= 1'b1;
            s1_key_reg   <= beat_key;
            s1_tag_reg   <= beat_tag;
            state_reg    <= IDLE;
          end else begin
            state_reg <= BODY;
          end
        end else if ((state_reg == BODY) && beat_eop) begin
          s1_valid_reg <= 1'b1;
          s1_key_reg   <= key_reg;
          s1_tag_reg   <= tag_reg;
          state_reg    <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_count_reg <= '0;
    end else if (err_event && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  logic [KEY_W-1:0]     rule_key_reg  [NUM_RULES];
  logic [KEY_W-1:0]     rule_mask_reg [NUM_RULES];
  logic [NUM_RULES-1:0] rule_en_reg;
  logic [NUM_RULES-1:0] hit_vec;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rule_en_reg <= '0;
    end else if (cfg_we) begin
      rule_en_reg[cfg_addr] <= cfg_en;
    end
  end

  always_ff @(posedge clock) begin
    if (cfg_we) begin
      rule_key_reg[cfg_addr]  <= cfg_key;
      rule_mask_reg[cfg_addr] <= cfg_mask;
    end
  end

  // Compare sees the table as it stands during S1; a same-cycle write lands afterwards.
  generate
    for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
      assign hit_vec[gi] = rule_en_reg[gi] &
                           (((s1_key_reg ^ rule_key_reg[gi]) & rule_mask_reg[gi]) == '0);
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid_reg <= 1'b0;
      s2_hit_reg   <= '0;
      s2_tag_reg   <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_hit_reg   <= hit_vec;
      s2_tag_reg   <= s1_tag_reg;
    end
  end

  logic             enc_hit;
  logic [IDX_W-1:0] enc_idx;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    enc_hit = 1'b0;
    enc_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (s2_hit_reg[i]) begin
        enc_hit = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
  end

  result_t          push_res;
  logic [RES_W-1:0] head_data;
  logic             head_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;

  assign push_res = '{hit: enc_hit, idx: enc_idx, tag: s2_tag_reg};
  assign pop      = head_valid & data_ack;

  hardmatch_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (s2_valid_reg),
    .push_data  (push_res),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Reservation total after this edge: opening a packet claims a slot, a pop frees one;
  // moving a packet from parser to pipe to FIFO leaves the total unchanged.
  logic [TOT_W-1:0] total_next;

  assign total_next = TOT_W'(fifo_count) + TOT_W'(state_reg == BODY) + TOT_W'(s1_valid_reg)
                    + TOT_W'(s2_valid_reg) + TOT_W'(open_pkt) - TOT_W'(pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= (total_next < TOT_W'(FIFO_DEPTH));
    end
  end

  assign pnode_ready = ready_reg;
  assign data_valid  = head_valid;
  assign data_out    = head_valid ? head_data : '0;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_hardmatchblock_param.sv
// Directed bench for hardmatchblock_param: streaming order, rule matching, back-pressure,
// protocol errors, table-write race and asynchronous reset.
module tb_hardmatchblock_param;

  localparam int DATA_W     = 128;
  localparam int TAG_W      = 8;
  localparam int KEY_W      = 32;
  localparam int KEY_LSB    = 96;
  localparam int NUM_RULES  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int BEAT_W     = DATA_W + 2 + TAG_W;
  localparam int RES_W      = 1 + 4 + TAG_W;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [BEAT_W-1:0] pnode_data = '0;
  logic              pnode_valid = 1'b0;
  logic              pnode_ready;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic              cfg_en = 1'b0;
  logic [KEY_W-1:0]  cfg_key = '0;
  logic [KEY_W-1:0]  cfg_mask = '0;
  logic              data_valid;
  logic              data_ack = 1'b0;
  logic [RES_W-1:0]  data_out;
  logic [15:0]       err_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  hardmatchblock_param #(
    .DATA_W     (DATA_W),
    .TAG_W      (TAG_W),
    .KEY_W      (KEY_W),
    .KEY_LSB    (KEY_LSB),
    .NUM_RULES  (NUM_RULES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .pnode_data  (pnode_data),
    .pnode_valid (pnode_valid),
    .pnode_ready (pnode_ready),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_en      (cfg_en),
    .cfg_key     (cfg_key),
    .cfg_mask    (cfg_mask),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .err_count   (err_count)
  );

  function automatic logic [BEAT_W-1:0] mk_beat(input logic [7:0] tag, input logic sop,
                                                input logic eop, input logic [31:0] key);
    logic [31:0] fill;
    fill = key ^ 32'h5A5A_5A5A;
    return {tag, sop, eop, key, fill, fill, fill};
  endfunction

  // All helpers start and end on a falling edge.
  task automatic send_beat(input logic [7:0] tag, input logic sop, input logic eop,
                           input logic [31:0] key, output bit ok);
    int guard = 0;
    pnode_data  = mk_beat(tag, sop, eop, key);
    pnode_valid = 1'b1;
    while (!pnode_ready && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    ok = pnode_ready;
    @(negedge clock);
    pnode_valid = 1'b0;
  endtask

  task automatic pop_result(output logic [RES_W-1:0] res, output bit ok);
    int guard = 0;
    while (!data_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    ok  = data_valid;
    res = data_out;
    if (ok) begin
      data_ack = 1'b1;
      @(negedge clock);
      data_ack = 1'b0;
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic en, input logic [31:0] key,
                           input logic [31:0] mask);
    cfg_we = 1'b1; cfg_addr = addr; cfg_en = en; cfg_key = key; cfg_mask = mask;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (pnode_ready !== 1'b0 || data_valid !== 1'b0 || data_out !== '0 || err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b out=%h err=%0d, expected 0 0 0 0",
               pnode_ready, data_valid, data_out, err_count);
    end else $display("[TB] reset_state ok");
    resetn = 1'b1;
    tests_run++;
    if (pnode_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 0 before first clock", pnode_ready);
    end
    @(negedge clock);
    tests_run++;
    if (pnode_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_rise: got %b expected 1", pnode_ready);
    end else $display("[TB] ready rises after release ok");
  endtask

  task automatic test_stream();
    int rx = 0;
    int cyc = 0;
    int send_fail = 0;
    bit held = 1'b0;
    logic [RES_W-1:0] held_val = '0;
    logic [RES_W-1:0] exp;
    fork
      begin
        bit ok;
        for (int t = 0; t < 256; t++) begin
          for (int b = 0; b < 6; b++) begin
            send_beat(8'(t), b == 0, b == 5, $urandom, ok);
            if (!ok) send_fail++;
          end
        end
      end
      begin
        while (rx < 256 && cyc < 20000) begin
          if (held) begin
            tests_run++;
            if (data_out !== held_val) begin
              tests_failed++;
              $display("FAIL stream_stable: got %h expected %h", data_out, held_val);
            end
          end
          data_ack = ($urandom_range(0, 3) == 0);
          if (data_valid && data_ack) begin
            exp = {1'b0, 4'd0, 8'(rx)};
            tests_run++;
            if (data_out !== exp) begin
              tests_failed++;
              $display("FAIL stream_result_%0d: got %h expected %h", rx, data_out, exp);
            end else $display("[TB] stream packet %0d result %h", rx, data_out);
            rx++;
            held = 1'b0;
          end else if (data_valid) begin
            held = 1'b1;
            held_val = data_out;
          end else begin
            held = 1'b0;
          end
          @(negedge clock);
          cyc++;
        end
        data_ack = 1'b0;
      end
    join
    tests_run++;
    if (rx != 256 || send_fail != 0) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d results (%0d send timeouts) expected 256 (0)", rx, send_fail);
    end
    repeat (4) @(negedge clock);
    tests_run++;
    if (err_count !== 16'd0 || data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_tail: err=%0d valid=%b expected 0 0", err_count, data_valid);
    end else $display("[TB] stream tail ok");
  endtask

  task automatic test_match();
    logic [31:0]      keys [4] = '{32'hDEAD_BEEF, 32'hDEAD_1234, 32'h0000_BEEF, 32'hDEAE_BEEF};
    logic [RES_W-1:0] exps [4] = '{{1'b1, 4'd1, 8'h5A}, {1'b1, 4'd1, 8'h61},
                                   {1'b0, 4'd0, 8'h62}, {1'b0, 4'd0, 8'h63}};
    logic [7:0]       tags [4] = '{8'h5A, 8'h61, 8'h62, 8'h63};
    logic [RES_W-1:0] res;
    bit ok;
    cfg_write(4'd3, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    cfg_write(4'd1, 1'b1, 32'hDEAD_0000, 32'hFFFF_0000);
    send_beat(8'h5A, 1'b1, 1'b1, 32'hDEAD_BEEF, ok);
    tests_run++;
    if (!ok || data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL match_lat1: valid=%b sent=%0b expected 0 1", data_valid, ok);
    end
    @(negedge clock);
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL match_lat2: valid=%b expected 0", data_valid);
    end
    @(negedge clock);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== exps[0]) begin
      tests_failed++;
      $display("FAIL match_lat3: valid=%b out=%h expected 1 %h", data_valid, data_out, exps[0]);
    end else $display("[TB] match latency 3 ok: %h", data_out);
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
    for (int i = 1; i < 4; i++) begin
      send_beat(tags[i], 1'b1, 1'b1, keys[i], ok);
      pop_result(res, ok);
      tests_run++;
      if (!ok || res !== exps[i]) begin
        tests_failed++;
        $display("FAIL match_%0d: got %h (valid %0b) expected %h", i, res, ok, exps[i]);
      end else $display("[TB] match key %h result %h", keys[i], res);
    end
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] exp;
    bit ok;
    int sent = 0;
    data_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(8'(8'h10 + i), 1'b1, 1'b1, 32'h0, ok);
      if (ok) sent++;
    end
    tests_run++;
    if (sent != 4 || pnode_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_fall: sent=%0d ready=%b expected 4 0", sent, pnode_ready);
    end else $display("[TB] ready fell after 4th packet");
    repeat (4) @(negedge clock);
    tests_run++;
    if (pnode_ready !== 1'b0 || data_valid !== 1'b1 || data_out !== {1'b0, 4'd0, 8'h10}) begin
      tests_failed++;
      $display("FAIL bp_hold: ready=%b valid=%b out=%h expected 0 1 %h",
               pnode_ready, data_valid, data_out, {1'b0, 4'd0, 8'h10});
    end
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
    tests_run++;
    if (pnode_ready !== 1'b1 || data_out !== {1'b0, 4'd0, 8'h11}) begin
      tests_failed++;
      $display("FAIL bp_release: ready=%b out=%h expected 1 %h", pnode_ready, data_out,
               {1'b0, 4'd0, 8'h11});
    end else $display("[TB] one pop reopened ready, head %h", data_out);
    send_beat(8'h14, 1'b1, 1'b1, 32'h0, ok);
    tests_run++;
    if (!ok || pnode_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_refill: sent=%0b ready=%b expected 1 0", ok, pnode_ready);
    end
    for (int i = 1; i < 5; i++) begin
      exp = {1'b0, 4'd0, 8'(8'h10 + i)};
      pop_result(res, ok);
      tests_run++;
      if (!ok || res !== exp) begin
        tests_failed++;
        $display("FAIL bp_drain_%0d: got %h (valid %0b) expected %h", i, res, ok, exp);
      end else $display("[TB] drained %h", res);
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%b expected 0", data_valid);
    end
  endtask

  task automatic test_errors();
    logic [RES_W-1:0] res;
    bit ok;
    bit all_ok = 1'b1;
    send_beat(8'h20, 1'b0, 1'b1, 32'h0, ok); all_ok &= ok;
    send_beat(8'h21, 1'b1, 1'b0, 32'h0, ok); all_ok &= ok;
    send_beat(8'h21, 1'b0, 1'b0, 32'h0, ok); all_ok &= ok;
    send_beat(8'h22, 1'b1, 1'b0, 32'h0, ok); all_ok &= ok;
    send_beat(8'h22, 1'b0, 1'b1, 32'h0, ok); all_ok &= ok;
    send_beat(8'h23, 1'b1, 1'b0, 32'h0, ok); all_ok &= ok;
    send_beat(8'h23, 1'b0, 1'b0, 32'h0, ok); all_ok &= ok;
    send_beat(8'h23, 1'b0, 1'b1, 32'h0, ok); all_ok &= ok;
    repeat (3) @(negedge clock);
    tests_run++;
    if (!all_ok || err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL err_count: got %0d (sent ok %0b) expected 2", err_count, all_ok);
    end else $display("[TB] err_count %0d", err_count);
    pop_result(res, ok);
    tests_run++;
    if (!ok || res !== {1'b0, 4'd0, 8'h22}) begin
      tests_failed++;
      $display("FAIL err_first_result: got %h (valid %0b) expected %h", res, ok, {1'b0, 4'd0, 8'h22});
    end else $display("[TB] err result %h", res);
    pop_result(res, ok);
    tests_run++;
    if (!ok || res !== {1'b0, 4'd0, 8'h23}) begin
      tests_failed++;
      $display("FAIL err_second_result: got %h (valid %0b) expected %h", res, ok, {1'b0, 4'd0, 8'h23});
    end else $display("[TB] err result %h", res);
    repeat (3) @(negedge clock);
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_no_extra: valid=%b expected 0", data_valid);
    end
  endtask

  task automatic test_cfg_race();
    logic [RES_W-1:0] res;
    bit ok;
    send_beat(8'h31, 1'b1, 1'b1, 32'hDEAD_BEEF, ok);
    // The packet is in S1 now; the disable write lands on the same edge as the compare.
    cfg_write(4'd1, 1'b0, 32'hDEAD_0000, 32'hFFFF_0000);
    pop_result(res, ok);
    tests_run++;
    if (!ok || res !== {1'b1, 4'd1, 8'h31}) begin
      tests_failed++;
      $display("FAIL race_old_table: got %h (valid %0b) expected %h", res, ok, {1'b1, 4'd1, 8'h31});
    end else $display("[TB] race result %h", res);
    send_beat(8'h32, 1'b1, 1'b1, 32'hDEAD_BEEF, ok);
    pop_result(res, ok);
    tests_run++;
    if (!ok || res !== {1'b1, 4'd3, 8'h32}) begin
      tests_failed++;
      $display("FAIL race_new_table: got %h (valid %0b) expected %h", res, ok, {1'b1, 4'd3, 8'h32});
    end else $display("[TB] race follow-up result %h", res);
  endtask

  task automatic test_async_reset();
    logic [RES_W-1:0] res;
    bit ok;
    bit all_ok = 1'b1;
    send_beat(8'h40, 1'b1, 1'b1, 32'h0, ok); all_ok &= ok;
    send_beat(8'h41, 1'b1, 1'b1, 32'h0, ok); all_ok &= ok;
    send_beat(8'h42, 1'b1, 1'b0, 32'h0, ok); all_ok &= ok;
    repeat (3) @(negedge clock);
    tests_run++;
    if (!all_ok || data_valid !== 1'b1 || err_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL arst_setup: valid=%b err=%0d sent=%0b expected 1 2 1", data_valid, err_count, all_ok);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (data_valid !== 1'b0 || err_count !== 16'd0 || pnode_ready !== 1'b0 || data_out !== '0) begin
      tests_failed++;
      $display("FAIL arst_immediate: valid=%b err=%0d ready=%b out=%h expected 0 0 0 0",
               data_valid, err_count, pnode_ready, data_out);
    end else $display("[TB] async reset cleared outputs");
    @(negedge clock);
    resetn = 1'b1;
    send_beat(8'h77, 1'b1, 1'b1, 32'hDEAD_BEEF, ok);
    pop_result(res, ok);
    tests_run++;
    if (!ok || res !== {1'b0, 4'd0, 8'h77}) begin
      tests_failed++;
      $display("FAIL arst_after: got %h (valid %0b) expected %h", res, ok, {1'b0, 4'd0, 8'h77});
    end else $display("[TB] post-reset result %h", res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_match();
    test_backpressure();
    test_errors();
    test_cfg_race();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
